// File: rtl/commit_result_queue.sv
// commit_result_queue: first-word-fall-through queue that sits between one
// instruction branch's result output and one lane of the commit stage.
// The head entry is presented combinationally so the commit stage can match
// commit_id in the same cycle. Every accepted push is also checked to confirm
// that commit IDs only move forward (modulo 512); a sticky flag records any
// violation.
module commit_result_queue #(
    parameter int data_width = 16,
    parameter int n_blocks   = 256,
    parameter int depth      = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          flush,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [$clog2(n_blocks)-1:0]   in_block,
    input  logic [2*data_width-1:0]       in_result,
    input  logic [3:0]                    in_dest,
    input  logic [8:0]                    in_commit_id,
    input  logic                          in_commit_flag,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(n_blocks)-1:0]   out_block,
    output logic [2*data_width-1:0]       out_result,
    output logic [3:0]                    out_dest,
    output logic [8:0]                    out_commit_id,
    output logic                          out_commit_flag,
    output logic [$clog2(depth+1)-1:0]    count,
    output logic                          almost_full,
    output logic                          order_err
);

    localparam int BW = $clog2(n_blocks);
    localparam int RW = 2 * data_width;
    localparam int PW = $clog2(depth);
    localparam int CW = $clog2(depth + 1);
    localparam int EW = BW + RW + 4 + 9 + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(depth);
    localparam logic [CW-1:0] AF_C    = CW'(depth - 1);

    // Entry layout: {block, result, dest, commit_id, commit_flag}
    logic [EW-1:0] mem_q [depth];
    logic [EW-1:0] mem_d [depth];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [8:0]    last_id_q, last_id_d;
    logic          last_vld_q, last_vld_d;
    logic          order_err_q, order_err_d;

    logic          push;
    logic          pop;
    logic [8:0]    id_diff;

    // in_ready looks only at registered occupancy, so there is no
    // combinational path from out_ready back to in_ready.
    assign in_ready    = enable & reset & (count_q < DEPTH_C);
    assign out_valid   = enable & (count_q != '0);
    assign push        = in_valid & in_ready;
    assign pop         = out_valid & out_ready;

    assign {out_block, out_result, out_dest, out_commit_id, out_commit_flag} = mem_q[rd_ptr_q];

    assign count       = count_q;
    assign almost_full = (count_q >= AF_C);
    assign order_err   = order_err_q;

    // Forward distance from the previous ID; 0 or the upper half of the
    // 9-bit ring means the branch went backwards or repeated an ID.
    assign id_diff     = in_commit_id - last_id_q;

    // Next-state: flush drops everything (including a same-cycle push/pop),
    // otherwise apply push/pop and the ordering check.
    always_comb begin
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        last_id_d   = last_id_q;
        last_vld_d  = last_vld_q;
        order_err_d = order_err_q;

        if (flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            last_vld_d = 1'b0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = {in_block, in_result, in_dest, in_commit_id, in_commit_flag};
                wr_ptr_d        = wr_ptr_q + 1'b1;
                if (last_vld_q && ((id_diff == '0) || id_diff[8])) begin
                    order_err_d = 1'b1;
                end
                last_id_d  = in_commit_id;
                last_vld_d = 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Entry storage carries no reset; only occupancy says what is valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Control state with synchronous active-low reset; reset wins over flush.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            last_id_q   <= '0;
            last_vld_q  <= 1'b0;
            order_err_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            last_id_q   <= last_id_d;
            last_vld_q  <= last_vld_d;
            order_err_q <= order_err_d;
        end
    end

endmodule

// File: tb/tb_commit_result_queue.sv
// Testbench for commit_result_queue: directed scenarios plus a randomized run
// checked against a queue-based reference model of the result queue.
module tb_commit_result_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset, enable, flush;
    logic        in_valid, in_ready;
    logic [7:0]  in_block;
    logic [31:0] in_result;
    logic [3:0]  in_dest;
    logic [8:0]  in_commit_id;
    logic        in_commit_flag;
    logic        out_valid, out_ready;
    logic [7:0]  out_block;
    logic [31:0] out_result;
    logic [3:0]  out_dest;
    logic [8:0]  out_commit_id;
    logic        out_commit_flag;
    logic [2:0]  count;
    logic        almost_full, order_err;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0]  blk;
        logic [31:0] res;
        logic [3:0]  dest;
        logic [8:0]  id;
        logic        flag;
    } ent_t;

    // Reference model state
    ent_t mq[$];
    bit   m_last_vld;
    int   m_last;
    bit   m_err;

    commit_result_queue #(.data_width(16), .n_blocks(256), .depth(DEPTH)) dut (
        .clk(clk), .reset(reset), .enable(enable), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_block(in_block),
        .in_result(in_result), .in_dest(in_dest), .in_commit_id(in_commit_id),
        .in_commit_flag(in_commit_flag), .out_valid(out_valid), .out_ready(out_ready),
        .out_block(out_block), .out_result(out_result), .out_dest(out_dest),
        .out_commit_id(out_commit_id), .out_commit_flag(out_commit_flag),
        .count(count), .almost_full(almost_full), .order_err(order_err)
    );

    always #5 clk = ~clk;

    // Advance the model by one clock using the currently driven inputs.
    task automatic model_step();
        bit   do_push, do_pop;
        int   d;
        ent_t e;
        if (reset !== 1'b1) begin
            mq.delete();
            m_last_vld = 0;
            m_err = 0;
        end else if (flush === 1'b1) begin
            mq.delete();
            m_last_vld = 0;
        end else if (enable === 1'b1) begin
            do_push = (in_valid === 1'b1) && (mq.size() < DEPTH);
            do_pop  = (out_ready === 1'b1) && (mq.size() > 0);
            if (do_pop) void'(mq.pop_front());
            if (do_push) begin
                if (m_last_vld) begin
                    d = (int'(in_commit_id) - m_last + 512) % 512;
                    if (d == 0 || d >= 256) m_err = 1;
                end
                m_last = int'(in_commit_id);
                m_last_vld = 1;
                e.blk = in_block; e.res = in_result; e.dest = in_dest;
                e.id = in_commit_id; e.flag = in_commit_flag;
                mq.push_back(e);
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_entry(input int id);
        in_commit_id   = 9'(id);
        in_block       = 8'($urandom);
        in_result      = $urandom;
        in_dest        = 4'($urandom);
        in_commit_flag = 1'($urandom);
    endtask

    task automatic test_reset();
        reset = 0; enable = 1; flush = 0; in_valid = 1; out_ready = 1;
        set_entry(100);
        tick(); tick();
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%0b want=0", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%0b want=0", out_valid); end
        total++; if (count !== 3'd0) begin bad++; $display("FAIL rst_count got=%0d want=0", count); end
        total++; if (almost_full !== 1'b0) begin bad++; $display("FAIL rst_af got=%0b want=0", almost_full); end
        total++; if (order_err !== 1'b0) begin bad++; $display("FAIL rst_err got=%0b want=0", order_err); end
        reset = 1; in_valid = 0; out_ready = 0;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_release_ready got=%0b want=1", in_ready); end
        tick();
    endtask

    task automatic test_fill();
        in_valid = 1; set_entry(5);
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL fill_no_bypass got=%0b want=0", out_valid); end
        tick();
        set_entry(6);
        #1;
        total++; if (out_valid !== 1'b1 || out_commit_id !== 9'd5) begin bad++; $display("FAIL fill_first_head vld=%0b id=%0d want 1/5", out_valid, out_commit_id); end
        tick();
        set_entry(7); tick();
        in_valid = 0;
        #1;
        total++; if (count !== 3'd3) begin bad++; $display("FAIL fill_count3 got=%0d want=3", count); end
        total++; if (almost_full !== 1'b1) begin bad++; $display("FAIL fill_af got=%0b want=1", almost_full); end
        total++; if (order_err !== 1'b0) begin bad++; $display("FAIL fill_err got=%0b want=0", order_err); end
        in_valid = 1; set_entry(8); tick();
        set_entry(9);
        #1;
        total++; if (count !== 3'd4 || in_ready !== 1'b0) begin bad++; $display("FAIL full_state count=%0d rdy=%0b want 4/0", count, in_ready); end
        tick();
        #1;
        total++; if (count !== 3'd4 || out_commit_id !== 9'd5) begin bad++; $display("FAIL full_hold count=%0d head=%0d want 4/5", count, out_commit_id); end
        out_ready = 1; tick();
        out_ready = 0;
        #1;
        total++; if (in_ready !== 1'b1 || count !== 3'd3 || out_commit_id !== 9'd6) begin bad++; $display("FAIL after_pop rdy=%0b count=%0d head=%0d want 1/3/6", in_ready, count, out_commit_id); end
        tick();
        in_valid = 0;
        #1;
        total++; if (count !== 3'd4) begin bad++; $display("FAIL id9_accept count=%0d want=4", count); end
        out_ready = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            total++; if (out_valid !== 1'b1 || out_commit_id !== 9'(6 + i)) begin bad++; $display("FAIL drain_%0d vld=%0b id=%0d want 1/%0d", i, out_valid, out_commit_id, 6 + i); end
            tick();
        end
        tick();
        #1;
        total++; if (count !== 3'd0 || out_valid !== 1'b0) begin bad++; $display("FAIL empty_underflow count=%0d vld=%0b want 0/0", count, out_valid); end
        out_ready = 0;
    endtask

    task automatic test_back_to_back();
        int got[$];
        int sent;
        int cyc;
        in_valid = 1; set_entry(10); tick();
        set_entry(11); tick();
        set_entry(12); out_ready = 1;
        #1;
        total++; if (count !== 3'd2) begin bad++; $display("FAIL pp_before count=%0d want=2", count); end
        tick();
        in_valid = 0; out_ready = 0;
        #1;
        total++; if (count !== 3'd2 || out_commit_id !== 9'd11) begin bad++; $display("FAIL pp_same count=%0d head=%0d want 2/11", count, out_commit_id); end
        out_ready = 1; tick(); tick();
        out_ready = 0; flush = 1; tick(); flush = 0;
        sent = 0; cyc = 0;
        while (got.size() < 10 && cyc < 200) begin
            in_valid = (sent < 10);
            set_entry(sent);
            out_ready = (sent >= 10) ? 1'b1 : 1'($urandom);
            #1;
            if (out_valid === 1'b1 && out_ready === 1'b1) got.push_back(int'(out_commit_id));
            if (in_valid === 1'b1 && in_ready === 1'b1) sent++;
            tick();
            cyc++;
        end
        in_valid = 0; out_ready = 0;
        total++; if (got.size() != 10) begin bad++; $display("FAIL wrap_count got=%0d want=10", got.size()); end
        for (int i = 0; i < got.size(); i++) begin
            total++; if (got[i] != i) begin bad++; $display("FAIL wrap_order idx=%0d got=%0d want=%0d", i, got[i], i); end
        end
    endtask

    task automatic test_order_wrap();
        int ids[5] = '{510, 511, 0, 1, 1};
        flush = 1; tick(); flush = 0;
        out_ready = 1; in_valid = 1;
        for (int i = 0; i < 4; i++) begin set_entry(ids[i]); tick(); end
        in_valid = 0;
        #1;
        total++; if (order_err !== 1'b0) begin bad++; $display("FAIL ord_wrap_legal got=%0b want=0", order_err); end
        in_valid = 1; set_entry(ids[4]); tick();
        in_valid = 0;
        #1;
        total++; if (order_err !== 1'b1) begin bad++; $display("FAIL ord_repeat got=%0b want=1", order_err); end
        flush = 1; tick(); flush = 0;
        #1;
        total++; if (order_err !== 1'b1) begin bad++; $display("FAIL ord_sticky_flush got=%0b want=1", order_err); end
        reset = 0; tick(); reset = 1;
        #1;
        total++; if (order_err !== 1'b0) begin bad++; $display("FAIL ord_reset_clear got=%0b want=0", order_err); end
        out_ready = 0;
    endtask

    task automatic test_flush();
        in_valid = 1;
        for (int i = 30; i < 33; i++) begin set_entry(i); tick(); end
        in_valid = 0;
        #1;
        total++; if (count !== 3'd3) begin bad++; $display("FAIL fl_pre count=%0d want=3", count); end
        flush = 1; in_valid = 1; set_entry(20); tick();
        flush = 0; in_valid = 0;
        #1;
        total++; if (count !== 3'd0 || out_valid !== 1'b0) begin bad++; $display("FAIL fl_clear count=%0d vld=%0b want 0/0", count, out_valid); end
        in_valid = 1; set_entry(3); tick();
        in_valid = 0;
        #1;
        total++; if (order_err !== 1'b0 || count !== 3'd1 || out_commit_id !== 9'd3) begin bad++; $display("FAIL fl_first_push err=%0b count=%0d head=%0d want 0/1/3", order_err, count, out_commit_id); end
    endtask

    task automatic test_enable();
        logic [31:0] saved;
        flush = 1; tick(); flush = 0;
        in_valid = 1; set_entry(40); saved = in_result; tick();
        set_entry(41); tick();
        enable = 0; out_ready = 1; set_entry(42);
        #1;
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin bad++; $display("FAIL en_off vld=%0b rdy=%0b want 0/0", out_valid, in_ready); end
        tick(); tick();
        #1;
        total++; if (count !== 3'd2) begin bad++; $display("FAIL en_hold count=%0d want=2", count); end
        enable = 1; in_valid = 0; out_ready = 0;
        #1;
        total++; if (out_valid !== 1'b1 || out_commit_id !== 9'd40 || out_result !== saved) begin bad++; $display("FAIL en_resume vld=%0b id=%0d res=%h want 1/40/%h", out_valid, out_commit_id, out_result, saved); end
        tick();
        flush = 1; tick(); flush = 0;
    endtask

    task automatic test_random();
        logic [8:0] next_id;
        int   sz;
        bit   e_rdy, e_vld;
        ent_t h;
        next_id = 9'd0;
        for (int c = 0; c < 800; c++) begin
            reset     = ($urandom_range(0, 99) != 0);
            enable    = ($urandom_range(0, 7) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            in_valid  = 1'($urandom);
            out_ready = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 15) == 0) next_id = 9'($urandom);
            else next_id = next_id + 9'($urandom_range(1, 3));
            set_entry(int'(next_id));
            #1;
            sz    = mq.size();
            e_rdy = reset && enable && (sz < DEPTH);
            e_vld = enable && (sz != 0);
            total++; if (in_ready !== e_rdy) begin bad++; $display("FAIL rnd_in_ready cyc=%0d got=%0b want=%0b", c, in_ready, e_rdy); end
            total++; if (out_valid !== e_vld) begin bad++; $display("FAIL rnd_out_valid cyc=%0d got=%0b want=%0b", c, out_valid, e_vld); end
            total++; if (count !== 3'(sz)) begin bad++; $display("FAIL rnd_count cyc=%0d got=%0d want=%0d", c, count, sz); end
            total++; if (almost_full !== (sz >= DEPTH - 1)) begin bad++; $display("FAIL rnd_af cyc=%0d got=%0b want=%0b", c, almost_full, sz >= DEPTH - 1); end
            total++; if (order_err !== m_err) begin bad++; $display("FAIL rnd_err cyc=%0d got=%0b want=%0b", c, order_err, m_err); end
            if (e_vld) begin
                h = mq[0];
                total++;
                if ({out_block, out_result, out_dest, out_commit_id, out_commit_flag} !== {h.blk, h.res, h.dest, h.id, h.flag}) begin
                    bad++;
                    $display("FAIL rnd_head cyc=%0d got=%h/%h/%h/%0d/%b want=%h/%h/%h/%0d/%b", c,
                             out_block, out_result, out_dest, out_commit_id, out_commit_flag,
                             h.blk, h.res, h.dest, h.id, h.flag);
                end
            end
            tick();
        end
        reset = 1; enable = 1; flush = 0; in_valid = 0; out_ready = 0;
    endtask

    initial begin
        reset = 0; enable = 0; flush = 0; in_valid = 0; out_ready = 0;
        set_entry(0);
        m_last_vld = 0; m_last = 0; m_err = 0;
        test_reset();
        test_fill();
        test_back_to_back();
        test_order_wrap();
        test_flush();
        test_enable();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
